// File: rtl/mem_access_sequencer.sv
// Splits one bus word access into byte accesses to N_TARGETS byte-wide targets, little-endian.
// Reads collect target bytes into o_bus_data with zero or sign fill; any fault ends in o_bus_err.
module mem_access_sequencer #(
  parameter int unsigned DATA_BYTES = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned N_TARGETS  = 2,
  parameter int unsigned TIMEOUT    = 255,
  localparam int unsigned NbW       = $clog2(DATA_BYTES) + 1,
  localparam int unsigned CntW      = ($clog2(TIMEOUT + 1) > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_bus_DV,
  input  logic [ADDR_WIDTH-1:0]     i_bus_address,
  input  logic [8*DATA_BYTES-1:0]   i_bus_data,
  input  logic [NbW-1:0]            i_nbytes,
  input  logic                      i_write_notread,
  input  logic                      i_signed,
  output logic [8*DATA_BYTES-1:0]   o_bus_data,
  output logic                      o_bus_DV,
  output logic                      o_bus_err,
  output logic                      o_busy,
  output logic [ADDR_WIDTH-1:0]     o_tgt_address,
  output logic [7:0]                o_tgt_data,
  output logic                      o_tgt_wren,
  output logic [N_TARGETS-1:0]      o_tgt_request,
  input  logic [N_TARGETS-1:0]      i_tgt_hit,
  input  logic [N_TARGETS-1:0]      i_tgt_done,
  input  logic [8*N_TARGETS-1:0]   i_tgt_data
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e                    state_q;
  logic [8*DATA_BYTES-1:0]   data_q;
  logic [8*DATA_BYTES-1:0]   data_next;
  logic [NbW-1:0]            nbytes_q;
  logic [NbW-1:0]            idx_q;
  logic                      sgn_q;
  logic [N_TARGETS-1:0]      sel_q;
  logic [CntW-1:0]           wait_cnt_q;

  logic [N_TARGETS-1:0]      hit_minus1;
  logic                      hit_onehot;
  logic                      sel_done;
  logic [7:0]                sel_byte;
  logic [7:0]                fill_byte;
  logic                      nbytes_bad;
  logic                      last_byte;

  assign data_next = data_q >> 8;

  always_comb begin
    hit_minus1 = i_tgt_hit - N_TARGETS'(1);
    hit_onehot = (i_tgt_hit != '0) && ((i_tgt_hit & hit_minus1) == '0);
    sel_done   = |(i_tgt_done & sel_q);
    sel_byte   = '0;
    for (int t = 0; t < int'(N_TARGETS); t++) begin
      if (sel_q[t]) sel_byte = i_tgt_data[8*t +: 8];
    end
    fill_byte  = sgn_q ? {8{sel_byte[7]}} : 8'h00;
    nbytes_bad = (i_nbytes == '0) || (i_nbytes > NbW'(DATA_BYTES));
    last_byte  = (idx_q + NbW'(1)) == nbytes_q;
  end

  // Request is decoded from the registered address in the same ISSUE cycle to keep 2 cycles/byte.
  assign o_tgt_request = ((state_q == StIssue) && hit_onehot) ? i_tgt_hit : '0;
  assign o_busy        = (state_q != StIdle);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= StIdle;
      data_q        <= '0;
      nbytes_q      <= '0;
      idx_q         <= '0;
      sgn_q         <= 1'b0;
      sel_q         <= '0;
      wait_cnt_q    <= '0;
      o_bus_data    <= '0;
      o_bus_DV      <= 1'b0;
      o_bus_err     <= 1'b0;
      o_tgt_address <= '0;
      o_tgt_data    <= '0;
      o_tgt_wren    <= 1'b0;
    end else begin
      o_bus_DV <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_bus_DV) begin
            data_q        <= i_bus_data;
            nbytes_q      <= i_nbytes;
            idx_q         <= '0;
            sgn_q         <= i_signed;
            sel_q         <= '0;
            o_tgt_address <= i_bus_address;
            o_tgt_data    <= i_bus_data[7:0];
            o_tgt_wren    <= i_write_notread & ~nbytes_bad;
            o_bus_data    <= '0;
            o_bus_err     <= nbytes_bad;
            state_q       <= nbytes_bad ? StResp : StIssue;
          end
        end
        StIssue: begin
          wait_cnt_q <= '0;
          if (hit_onehot) begin
            sel_q   <= i_tgt_hit;
            state_q <= StWait;
          end else begin
            o_bus_err <= 1'b1;
            state_q   <= StResp;
          end
        end
        StWait: begin
          if (sel_done) begin
            // Bytes above the current one take the fill now, so the final word is ready in RESP.
            if (!o_tgt_wren) begin
              for (int j = 0; j < int'(DATA_BYTES); j++) begin
                if (NbW'(j) == idx_q) o_bus_data[8*j +: 8] <= sel_byte;
                else if (NbW'(j) > idx_q) o_bus_data[8*j +: 8] <= fill_byte;
              end
            end
            o_tgt_address <= o_tgt_address + ADDR_WIDTH'(1);
            o_tgt_data    <= data_next[7:0];
            data_q        <= data_next;
            idx_q         <= idx_q + NbW'(1);
            sel_q         <= '0;
            state_q       <= last_byte ? StResp : StIssue;
          end else if (wait_cnt_q == CntW'(TIMEOUT - 1)) begin
            o_bus_err <= 1'b1;
            sel_q     <= '0;
            state_q   <= StResp;
          end else begin
            wait_cnt_q <= wait_cnt_q + CntW'(1);
          end
        end
        StResp: begin
          o_bus_DV   <= 1'b1;
          o_tgt_wren <= 1'b0;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench for mem_access_sequencer: behavioural byte targets answer one cycle after a
// request; expected words, latencies and target traffic are hand-computed constants.
module tb_mem_access_sequencer;

  localparam int unsigned Tmo = 255;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_bus_DV;
  logic [31:0] i_bus_address;
  logic [31:0] i_bus_data;
  logic [2:0]  i_nbytes;
  logic        i_write_notread;
  logic        i_signed;
  logic [31:0] o_bus_data;
  logic        o_bus_DV;
  logic        o_bus_err;
  logic        o_busy;
  logic [31:0] o_tgt_address;
  logic [7:0]  o_tgt_data;
  logic        o_tgt_wren;
  logic [1:0]  o_tgt_request;
  logic [1:0]  i_tgt_hit;
  logic [1:0]  i_tgt_done;
  logic [15:0] i_tgt_data;

  logic [1:0]  hit_vec = 2'b01;
  logic [1:0]  mdl_done = 2'b00;
  logic [1:0]  pend = 2'b00;
  logic [1:0]  force_done = 2'b00;
  logic        noise_en = 1'b1;
  logic [15:0] tgt_data = '0;
  logic [7:0]  rd_mem [4];
  int          resp_limit = 1000;
  int          resp_cnt = 0;
  int          req_cnt = 0;
  int          dv_cnt = 0;
  logic [31:0] log_addr [8];
  logic [7:0]  log_data [8];
  logic        log_wren [8];

  int n_checks = 0;
  int n_fail = 0;

  assign i_tgt_hit  = hit_vec;
  assign i_tgt_done = mdl_done | force_done | (noise_en ? ~hit_vec : 2'b00);
  assign i_tgt_data = tgt_data;

  mem_access_sequencer #(
    .DATA_BYTES(4),
    .ADDR_WIDTH(32),
    .N_TARGETS (2),
    .TIMEOUT   (Tmo)
  ) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_bus_DV       (i_bus_DV),
    .i_bus_address  (i_bus_address),
    .i_bus_data     (i_bus_data),
    .i_nbytes       (i_nbytes),
    .i_write_notread(i_write_notread),
    .i_signed       (i_signed),
    .o_bus_data     (o_bus_data),
    .o_bus_DV       (o_bus_DV),
    .o_bus_err      (o_bus_err),
    .o_busy         (o_busy),
    .o_tgt_address  (o_tgt_address),
    .o_tgt_data     (o_tgt_data),
    .o_tgt_wren     (o_tgt_wren),
    .o_tgt_request  (o_tgt_request),
    .i_tgt_hit      (i_tgt_hit),
    .i_tgt_done     (i_tgt_done),
    .i_tgt_data     (i_tgt_data)
  );

  always #5 i_clk = ~i_clk;

  // Target model: done one cycle after the request; non-hit targets return junk 0xAA.
  always @(negedge i_clk) begin
    mdl_done = pend;
    pend = 2'b00;
    if (|o_tgt_request) begin
      log_addr[req_cnt % 8] = o_tgt_address;
      log_data[req_cnt % 8] = o_tgt_data;
      log_wren[req_cnt % 8] = o_tgt_wren;
      req_cnt++;
      if (resp_cnt < resp_limit) begin
        pend = o_tgt_request;
        resp_cnt++;
      end
    end
    if (o_bus_DV) dv_cnt++;
    for (int t = 0; t < 2; t++) begin
      tgt_data[8*t +: 8] = hit_vec[t] ? rd_mem[o_tgt_address[1:0]] : 8'hAA;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_txn(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] nb,
                         input logic wr, input logic sg, output int cyc,
                         output logic [31:0] rdata, output logic err);
    bit seen;
    seen  = 1'b0;
    cyc   = 0;
    rdata = '0;
    err   = 1'b0;
    @(negedge i_clk);
    i_bus_address   = addr;
    i_bus_data      = data;
    i_nbytes        = nb;
    i_write_notread = wr;
    i_signed        = sg;
    i_bus_DV        = 1'b1;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(posedge i_clk);
      #1;
      cyc++;
      if (i == 0) i_bus_DV = 1'b0;
      if (o_bus_DV) begin
        seen  = 1'b1;
        rdata = o_bus_data;
        err   = o_bus_err;
      end
    end
    check("dv_seen", 64'(seen), 64'd1);
  endtask

  int          cyc;
  logic [31:0] rd;
  logic        er;
  int          r0;
  int          d0;

  initial begin
    i_rst = 1'b1;
    i_bus_DV = 1'b0;
    i_bus_address = '0;
    i_bus_data = '0;
    i_nbytes = '0;
    i_write_notread = 1'b0;
    i_signed = 1'b0;
    for (int i = 0; i < 4; i++) rd_mem[i] = 8'h00;
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_flags", {60'd0, o_bus_DV, o_bus_err, o_busy, o_tgt_wren}, 64'd0);
    check("rst_req", 64'(o_tgt_request), 64'd0);
    check("rst_data", {o_bus_data, o_tgt_address}, 64'd0);
    check("rst_tdata", 64'(o_tgt_data), 64'd0);
    @(negedge i_clk);
    i_rst = 1'b0;

    // Word read, target 0, junk done/data on target 1
    rd_mem[0] = 8'h11; rd_mem[1] = 8'h22; rd_mem[2] = 8'h33; rd_mem[3] = 8'h44;
    r0 = req_cnt;
    run_txn(32'h100, 32'h0, 3'd4, 1'b0, 1'b0, cyc, rd, er);
    check("word_rd_data", 64'(rd), 64'h44332211);
    check("word_rd_err", 64'(er), 64'd0);
    check("word_rd_lat", 64'(cyc), 64'd10);
    check("word_rd_reqs", 64'(req_cnt - r0), 64'd4);

    // Halfword write
    r0 = req_cnt;
    run_txn(32'h2000, 32'h1234BEEF, 3'd2, 1'b1, 1'b0, cyc, rd, er);
    check("hw_wr_data", 64'(rd), 64'd0);
    check("hw_wr_lat", 64'(cyc), 64'd6);
    check("hw_wr_b0", {log_addr[r0 % 8], 24'd0, log_data[r0 % 8]}, {32'h2000, 32'hEF});
    check("hw_wr_b1", {log_addr[(r0+1) % 8], 24'd0, log_data[(r0+1) % 8]}, {32'h2001, 32'hBE});
    check("hw_wr_wren", {62'd0, log_wren[r0 % 8], log_wren[(r0+1) % 8]}, 64'd3);

    // Signed / unsigned byte reads
    rd_mem[0] = 8'h80;
    run_txn(32'h300, 32'h0, 3'd1, 1'b0, 1'b1, cyc, rd, er);
    check("sbyte_data", 64'(rd), 64'hFFFFFF80);
    check("sbyte_lat", 64'(cyc), 64'd4);
    run_txn(32'h300, 32'h0, 3'd1, 1'b0, 1'b0, cyc, rd, er);
    check("ubyte_data", 64'(rd), 64'h00000080);

    // Signed halfword
    rd_mem[0] = 8'h34; rd_mem[1] = 8'h92;
    run_txn(32'h200, 32'h0, 3'd2, 1'b0, 1'b1, cyc, rd, er);
    check("shw_data", 64'(rd), 64'hFFFF9234);

    // Address wrap at top of space
    rd_mem[3] = 8'h5A; rd_mem[0] = 8'h11;
    r0 = req_cnt;
    run_txn(32'hFFFFFFFF, 32'h0, 3'd2, 1'b0, 1'b0, cyc, rd, er);
    check("wrap_data", 64'(rd), 64'h0000115A);
    check("wrap_addr1", 64'(log_addr[(r0+1) % 8]), 64'd0);

    // Target 1 selected, junk from target 0
    hit_vec = 2'b10;
    rd_mem[0] = 8'hDE; rd_mem[1] = 8'hAD; rd_mem[2] = 8'hBE; rd_mem[3] = 8'hEF;
    run_txn(32'h400, 32'h0, 3'd4, 1'b0, 1'b0, cyc, rd, er);
    check("tgt1_data", 64'(rd), 64'hEFBEADDE);
    check("tgt1_err", 64'(er), 64'd0);

    // Unmapped and multiply-decoded addresses
    hit_vec = 2'b00;
    r0 = req_cnt;
    run_txn(32'h500, 32'h0, 3'd4, 1'b0, 1'b0, cyc, rd, er);
    check("unmap_err", 64'(er), 64'd1);
    check("unmap_lat", 64'(cyc), 64'd3);
    check("unmap_reqs", 64'(req_cnt - r0), 64'd0);
    check("unmap_data", 64'(rd), 64'd0);
    hit_vec = 2'b11;
    run_txn(32'h500, 32'h0, 3'd1, 1'b0, 1'b0, cyc, rd, er);
    check("multi_err", 64'(er), 64'd1);
    check("multi_reqs", 64'(req_cnt - r0), 64'd0);

    // Timeout with no done at all
    hit_vec = 2'b01;
    resp_cnt = 0;
    resp_limit = 0;
    run_txn(32'h600, 32'h0, 3'd4, 1'b0, 1'b1, cyc, rd, er);
    check("tmo_err", 64'(er), 64'd1);
    check("tmo_lat", 64'(cyc), 64'(Tmo + 3));
    check("tmo_data", 64'(rd), 64'd0);

    // Timeout on byte 1: byte 0 retained
    rd_mem[0] = 8'h77;
    resp_cnt = 0;
    resp_limit = 1;
    run_txn(32'h700, 32'h0, 3'd2, 1'b0, 1'b0, cyc, rd, er);
    check("part_err", 64'(er), 64'd1);
    check("part_data", 64'(rd), 64'h00000077);
    check("part_lat", 64'(cyc), 64'(Tmo + 5));

    // Illegal byte counts
    resp_limit = 1000;
    r0 = req_cnt;
    run_txn(32'h800, 32'h0, 3'd0, 1'b0, 1'b0, cyc, rd, er);
    check("nb0_err", 64'(er), 64'd1);
    check("nb0_lat", 64'(cyc), 64'd2);
    run_txn(32'h800, 32'h0, 3'd5, 1'b1, 1'b0, cyc, rd, er);
    check("nb5_err", 64'(er), 64'd1);
    check("nbad_reqs", 64'(req_cnt - r0), 64'd0);

    // Reset while waiting on byte 2; request in the same cycle must lose to reset
    rd_mem[0] = 8'h11; rd_mem[1] = 8'h22; rd_mem[2] = 8'h33; rd_mem[3] = 8'h44;
    resp_cnt = 0;
    resp_limit = 2;
    r0 = req_cnt;
    @(negedge i_clk);
    i_bus_address = 32'h100;
    i_nbytes = 3'd4;
    i_write_notread = 1'b0;
    i_signed = 1'b0;
    i_bus_DV = 1'b1;
    @(negedge i_clk);
    i_bus_DV = 1'b0;
    for (int i = 0; i < 30 && req_cnt != r0 + 3; i++) @(negedge i_clk);
    check("rst_reach_b2", 64'(req_cnt - r0), 64'd3);
    @(negedge i_clk);
    d0 = dv_cnt;
    i_rst = 1'b1;
    i_bus_DV = 1'b1;
    i_write_notread = 1'b1;
    i_nbytes = 3'd1;
    @(posedge i_clk);
    #1;
    check("mid_rst_busy", 64'(o_busy), 64'd0);
    check("mid_rst_addr", 64'(o_tgt_address), 64'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    i_bus_DV = 1'b0;
    force_done = 2'b01;
    @(negedge i_clk);
    force_done = 2'b00;
    repeat (4) @(negedge i_clk);
    check("late_done_dv", 64'(dv_cnt - d0), 64'd0);
    check("late_done_req", 64'(req_cnt - r0), 64'd3);
    check("late_done_busy", 64'(o_busy), 64'd0);
    resp_limit = 1000;
    run_txn(32'h100, 32'h0, 3'd4, 1'b0, 1'b0, cyc, rd, er);
    check("post_rst_data", 64'(rd), 64'h44332211);
    check("post_rst_lat", 64'(cyc), 64'd10);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_sequencer.md
MEM_ACCESS_SEQUENCER -- requirements
Module: mem_access_sequencer

Interface
REQ-001 SHALL have parameter DATA_BYTES, default 4, meaning bus word width in bytes (1..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, meaning bus/target address width.
REQ-003 SHALL have parameter N_TARGETS, default 2, meaning number of byte-wide target submodules (1..8).
REQ-004 SHALL have parameter TIMEOUT, default 255, meaning max cycles waiting for one target byte.
REQ-005 SHALL have one clock and a synchronous, active-high reset: i_clk  in  1  clock, all logic on rising edge; i_rst  in  1  synchronous active-high reset.
REQ-006 SHALL have i_bus_DV  in  1  request strobe; i_bus_address  in  ADDR_WIDTH  start byte address; i_bus_data  in  8*DATA_BYTES  write data.
REQ-007 SHALL have i_nbytes  in  clog2(DATA_BYTES)+1  byte count; i_write_notread  in  1  1=write; i_signed  in  1  sign-extend reads.
REQ-008 SHALL have o_bus_data  out  8*DATA_BYTES  read data; o_bus_DV  out  1  completion pulse; o_bus_err  out  1  error flag, valid with o_bus_DV; o_busy  out  1  transaction in progress.
REQ-009 SHALL have o_tgt_address  out  ADDR_WIDTH  current byte address; o_tgt_data  out  8  write byte; o_tgt_wren  out  1; o_tgt_request  out  N_TARGETS  one-hot request pulse.
REQ-010 SHALL have i_tgt_hit  in  N_TARGETS  external address decode of o_tgt_address; i_tgt_done  in  N_TARGETS  per-target byte done; i_tgt_data  in  8*N_TARGETS  per-target read byte.

Function
REQ-011 SHALL implement states IDLE, ISSUE, WAIT, RESP.
REQ-012 SHALL, in IDLE with i_bus_DV=1, latch address, data, i_nbytes, i_write_notread, i_signed, clear o_bus_data and o_bus_err, and go to ISSUE; i_bus_DV outside IDLE SHALL be ignored.
REQ-013 SHALL treat i_nbytes=0 or i_nbytes>DATA_BYTES as error: IDLE->RESP directly with o_bus_err=1 and no target access.
REQ-014 SHALL, in ISSUE, check i_tgt_hit: exactly one bit set -> drive o_tgt_request on that bit for exactly one cycle, go to WAIT; zero or multiple bits -> o_bus_err=1, go to RESP.
REQ-015 SHALL route byte k (0-based) of the latched data to address start+k (little-endian); o_tgt_data=byte k throughout ISSUE/WAIT of byte k.
REQ-016 SHALL hold o_tgt_address, o_tgt_data, o_tgt_wren stable from ISSUE until the selected target's done.
REQ-017 SHALL, in WAIT, on i_tgt_done of the selected target: for reads store that target's i_tgt_data byte into o_bus_data byte k; increment address and k; go to ISSUE if bytes remain, else RESP.
REQ-018 SHALL ignore i_tgt_done and i_tgt_data from non-selected targets.
REQ-019 SHALL count WAIT cycles per byte; reaching TIMEOUT without done SHALL set o_bus_err=1 and go to RESP, aborting remaining bytes.
REQ-020 SHALL, in RESP, pulse o_bus_DV for exactly one cycle, then return to IDLE.
REQ-021 SHALL zero-fill read bytes >= i_nbytes, or fill with bit 7 of the last read byte when i_signed=1; sign extension SHALL be applied by the RESP cycle.
REQ-022 SHALL keep o_bus_data all-zero for writes and for errored reads no bytes of which completed; bytes completed before error SHALL be retained.
REQ-023 SHALL wrap address increment modulo 2^ADDR_WIDTH.
REQ-024 SHALL drive o_busy=1 in every state except IDLE.
REQ-025 SHALL give minimum latency, for N bytes each done 1 cycle after request, of 2N+2 cycles from accepting i_bus_DV to o_bus_DV.

Reset
REQ-026 SHALL, on i_rst=1 at a clock edge, enter IDLE and drive o_bus_DV=0, o_bus_err=0, o_busy=0, o_tgt_request=0, o_tgt_wren=0, o_bus_data=0, o_tgt_address=0, o_tgt_data=0.
REQ-027 SHALL, on reset mid-transaction, abandon it without issuing further requests or o_bus_DV; a done arriving after reset SHALL be ignored.
REQ-028 SHALL have reset priority over i_bus_DV in the same cycle.

Verification
REQ-029 SHALL verify word read: addr 0x100, nbytes=4, target0 hit, bytes 0x11,0x22,0x33,0x44 -> o_bus_data=0x44332211, err=0, o_bus_DV after 10 cycles.
REQ-030 SHALL verify halfword write: addr 0x2000, data 0xXXXXBEEF, nbytes=2 -> target sees 0xEF at 0x2000 then 0xBE at 0x2001, wren=1, o_bus_data=0.
REQ-031 SHALL verify signed byte read: byte 0x80, i_signed=1 -> 0xFFFFFF80; i_signed=0 -> 0x00000080.
REQ-032 SHALL verify unmapped/timeout: i_tgt_hit=0 -> err=1, no request; hit with no done -> err=1 after TIMEOUT cycles.
REQ-033 SHALL verify reset during WAIT of byte 2: no o_bus_DV, o_busy=0 next cycle, late done ignored, next request completes normally.
REQ-034 SHALL verify i_nbytes=0 -> o_bus_DV with err=1 two cycles after acceptance, no o_tgt_request.
